// File: rtl/ball_controller_if.sv
// ball_controller_if: frame tick, serve and paddle inputs plus ball position and goal outputs.
interface ball_controller_if;
    logic        i_timing_tick;
    logic        i_serve;
    logic [10:0] i_y_pad_left;
    logic [10:0] i_y_pad_right;
    logic [10:0] o_x_ball;
    logic [10:0] o_y_ball;
    logic        o_goal_left;
    logic        o_goal_right;
    logic        o_ball_active;
    modport master (
        output i_timing_tick, i_serve, i_y_pad_left, i_y_pad_right,
        input  o_x_ball, o_y_ball, o_goal_left, o_goal_right, o_ball_active
    );
    modport slave (
        input  i_timing_tick, i_serve, i_y_pad_left, i_y_pad_right,
        output o_x_ball, o_y_ball, o_goal_left, o_goal_right, o_ball_active
    );
endinterface

// File: rtl/ball_controller.sv
// ball_controller: Pong ball FSM (IDLE/MOVE/SCORED) with wall, paddle and goal handling.
// Define BALL_SPEEDUP_EN to add one pixel of step per paddle hit, saturating at 2*SPEED.
module ball_controller #(
    parameter int SCREEN_W   = 1024,
    parameter int SCREEN_H   = 768,
    parameter int BALL_SIZE  = 15,
    parameter int X_PAD_L    = 30,
    parameter int X_PAD_R    = 979,
    parameter int PAD_H      = 100,
    parameter int SPEED      = 4,
    parameter int HOLD_TICKS = 60
) (
    input logic clk,
    input logic rst,
    ball_controller_if.slave bus
);
    localparam logic [11:0] BSZ    = 12'(BALL_SIZE);
    localparam logic [11:0] X_MAX  = 12'(SCREEN_W - BALL_SIZE);
    localparam logic [11:0] Y_MAX  = 12'(SCREEN_H - BALL_SIZE);
    localparam logic [11:0] XPL    = 12'(X_PAD_L);
    localparam logic [11:0] XPR    = 12'(X_PAD_R);
    localparam logic [11:0] PADH   = 12'(PAD_H);
    localparam logic [11:0] X_LAST = 12'(SCREEN_W - 1);
    localparam logic [10:0] X_CTR  = 11'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [10:0] Y_CTR  = 11'((SCREEN_H - BALL_SIZE) / 2);
    localparam int HW = $clog2(HOLD_TICKS + 1);

    typedef enum logic [1:0] {IDLE, MOVE, SCORED} state_t;

    state_t      r_state, w_state_nxt;
    logic [10:0] r_x, r_y, w_x_nxt, w_y_nxt;
    logic        r_dir_r, r_dir_d, r_serve_up, r_goal_l, r_goal_r, r_active;
    logic        w_dir_r_nxt, w_dir_d_nxt;
    logic [HW-1:0] r_hold;
    logic [11:0] w_step, w_x, w_y, w_xl, w_xr, w_yu, w_yd, w_pl, w_pr;
    logic        w_mv, w_srv, w_hold_done, w_ov_l, w_ov_r;
    logic        w_goal_l, w_goal_r, w_hit_l, w_hit_r, w_top, w_bot;

`ifdef BALL_SPEEDUP_EN
    logic [11:0] r_step;
    always_ff @(posedge clk) begin
        if (!rst || w_goal_l || w_goal_r)
            r_step <= 12'(SPEED);
        else if ((w_hit_l || w_hit_r) && r_step < 12'(2 * SPEED))
            r_step <= r_step + 12'd1;
    end
    assign w_step = r_step;
`else
    assign w_step = 12'(SPEED);
`endif

    // Walls and goals test the current position; paddles test the candidate position after the step.
    always_comb begin
        w_x         = {1'b0, r_x};
        w_y         = {1'b0, r_y};
        w_pl        = {1'b0, bus.i_y_pad_left};
        w_pr        = {1'b0, bus.i_y_pad_right};
        w_xl        = w_x - w_step;
        w_xr        = w_x + w_step;
        w_yu        = w_y - w_step;
        w_yd        = w_y + w_step;
        w_mv        = r_state == MOVE && bus.i_timing_tick;
        w_srv       = r_state == IDLE && bus.i_serve;
        w_hold_done = r_hold == HW'(HOLD_TICKS - 1);
        w_ov_l      = w_y + BSZ > w_pl && w_y < w_pl + PADH;
        w_ov_r      = w_y + BSZ > w_pr && w_y < w_pr + PADH;
        w_goal_l    = w_mv && !r_dir_r && w_x < w_step;
        w_goal_r    = w_mv && r_dir_r && w_xr + BSZ > X_LAST;
        w_hit_l     = w_mv && !r_dir_r && !w_goal_l && w_ov_l && w_xl <= XPL && w_xl + w_step + 12'd1 > XPL;
        w_hit_r     = w_mv && r_dir_r && !w_goal_r && w_ov_r && w_xr + BSZ >= XPR && w_xr + BSZ < XPR + w_step + 12'd1;
        w_top       = w_mv && !r_dir_d && w_y <= w_step;
        w_bot       = w_mv && r_dir_d && w_yd >= Y_MAX;
    end

    always_comb begin
        case (r_state)
            IDLE:    w_state_nxt = bus.i_serve ? MOVE : IDLE;
            MOVE:    w_state_nxt = (w_goal_l || w_goal_r) ? SCORED : MOVE;
            SCORED:  w_state_nxt = (bus.i_timing_tick && w_hold_done) ? IDLE : SCORED;
            default: w_state_nxt = IDLE;
        endcase
    end

    // dir_x is left alone after a goal, so it already points at the player who conceded.
    always_comb begin
        w_x_nxt = w_state_nxt == IDLE ? X_CTR : !w_mv ? r_x : w_goal_l ? 11'd0 : w_goal_r ? 11'(X_MAX) :
                  w_hit_l ? 11'(XPL) : w_hit_r ? 11'(XPR - BSZ) : r_dir_r ? 11'(w_xr) : 11'(w_xl);
        w_y_nxt = w_state_nxt == IDLE ? Y_CTR : !w_mv ? r_y : w_top ? 11'd0 : w_bot ? 11'(Y_MAX) :
                  r_dir_d ? 11'(w_yd) : 11'(w_yu);
        w_dir_r_nxt = w_hit_l ? 1'b1 : w_hit_r ? 1'b0 : r_dir_r;
        w_dir_d_nxt = w_srv ? !r_serve_up : w_top ? 1'b1 : w_bot ? 1'b0 : r_dir_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_x        <= X_CTR;
            r_y        <= Y_CTR;
            r_dir_r    <= 1'b1;
            r_dir_d    <= 1'b1;
            r_serve_up <= 1'b0;
            r_goal_l   <= 1'b0;
            r_goal_r   <= 1'b0;
            r_active   <= 1'b0;
            r_hold     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_x        <= w_x_nxt;
            r_y        <= w_y_nxt;
            r_dir_r    <= w_dir_r_nxt;
            r_dir_d    <= w_dir_d_nxt;
            r_serve_up <= r_serve_up ^ w_srv;
            r_goal_l   <= w_goal_l;
            r_goal_r   <= w_goal_r;
            r_active   <= w_state_nxt == MOVE;
            r_hold     <= (r_state == SCORED && bus.i_timing_tick) ? (w_hold_done ? '0 : r_hold + HW'(1)) : r_hold;
        end
    end

    assign bus.o_x_ball      = r_x;
    assign bus.o_y_ball      = r_y;
    assign bus.o_goal_left   = r_goal_l;
    assign bus.o_goal_right  = r_goal_r;
    assign bus.o_ball_active = r_active;
endmodule

// File: tb/tb_ball_controller.sv
// tb_ball_controller: directed vector table, hand-written rally sequences and random play against a reference model.
module tb_ball_controller;
    localparam int W = 1024, H = 768, B = 15, XPL = 30, XPR = 979, PH = 100, SP = 4, HOLD = 60;
    localparam int CX = 504, CY = 376;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ball_controller_if bus();
    ball_controller dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0, bad = 0;
    int mmode, mx, my, vx, vy, serves, hold, mstep, mgl, mgr, mhits;
    int pad_l = 1000, pad_r = 1000;
    bit follow_l = 0, follow_r = 0;

    typedef struct { bit r; bit t; bit s; int n; int ex; int ey; int ea; string nm; } vec_t;
    vec_t tbl[6];

    function automatic void m_reset();
        mmode = 0; mx = CX; my = CY; vx = 1; vy = 1;
        serves = 0; hold = 0; mstep = SP; mgl = 0; mgr = 0;
    endfunction

    // mode: 0 idle, 1 moving, 2 scored; velocity is a sign times the current step.
    function automatic void m_step(bit t, bit s, int pl, int pr);
        int nx, ny;
        mgl = 0; mgr = 0;
        if (mmode == 0) begin
            if (s) begin
                mmode = 1;
                vy = (serves % 2 == 0) ? 1 : -1;
                serves++;
            end
        end else if (mmode == 1 && t) begin
            nx = mx + vx * mstep;
            ny = my + vy * mstep;
            if (vx < 0 && mx < mstep) begin mx = 0; mgl = 1; end
            else if (vx > 0 && mx + B > W - 1 - mstep) begin mx = W - B; mgr = 1; end
            else if (vx < 0 && nx <= XPL && nx > XPL - mstep - 1 && my + B > pl && my < pl + PH) begin
                mx = XPL; vx = 1; mhits++;
`ifdef BALL_SPEEDUP_EN
                mstep = (mstep + 1 > 2 * SP) ? 2 * SP : mstep + 1;
`endif
            end else if (vx > 0 && nx + B >= XPR && nx + B < XPR + mstep + 1 && my + B > pr && my < pr + PH) begin
                mx = XPR - B; vx = -1; mhits++;
`ifdef BALL_SPEEDUP_EN
                mstep = (mstep + 1 > 2 * SP) ? 2 * SP : mstep + 1;
`endif
            end else mx = nx;
            if (vy < 0 && my <= mstep) begin my = 0; vy = 1; end
            else if (vy > 0 && my + mstep >= H - B) begin my = H - B; vy = -1; end
            else my = ny;
            if (mgl == 1 || mgr == 1) begin mmode = 2; hold = 0; mstep = SP; end
        end else if (mmode == 2 && t) begin
            hold++;
            if (hold == HOLD) begin mmode = 0; mx = CX; my = CY; end
        end
    endfunction

    task automatic expect_v(string nm, int got, int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic cyc(bit r, bit t, bit s);
        rst = r;
        bus.i_timing_tick = t;
        bus.i_serve = s;
        bus.i_y_pad_left  = follow_l ? 11'(my) : 11'(pad_l);
        bus.i_y_pad_right = follow_r ? 11'(my) : 11'(pad_r);
        @(posedge clk);
        if (!r) m_reset();
        else m_step(t, s, int'(bus.i_y_pad_left), int'(bus.i_y_pad_right));
        @(negedge clk);
        total++;
        if (int'(bus.o_x_ball) != mx || int'(bus.o_y_ball) != my || bus.o_ball_active != (mmode == 1) ||
            int'(bus.o_goal_left) != mgl || int'(bus.o_goal_right) != mgr) begin
            bad++;
            if (bad <= 20)
                $display("FAIL model t=%0t got x=%0d y=%0d act=%0b gl=%0b gr=%0b want x=%0d y=%0d act=%0b gl=%0d gr=%0d",
                         $time, bus.o_x_ball, bus.o_y_ball, bus.o_ball_active, bus.o_goal_left, bus.o_goal_right,
                         mx, my, mmode == 1, mgl, mgr);
        end
    endtask

    initial begin
        int k;
        m_reset();
        mhits = 0;
        bus.i_timing_tick = 0; bus.i_serve = 0;
        bus.i_y_pad_left = 11'd1000; bus.i_y_pad_right = 11'd1000;
        tbl[0] = '{0, 0, 0, 2, 504, 376, 0, "reset"};
        tbl[1] = '{1, 1, 0, 3, 504, 376, 0, "idle ticks"};
        tbl[2] = '{1, 0, 1, 1, 504, 376, 1, "serve"};
        tbl[3] = '{1, 0, 0, 5, 504, 376, 1, "no tick no motion"};
        tbl[4] = '{1, 1, 0, 10, 544, 416, 1, "ten ticks"};
        tbl[5] = '{0, 0, 0, 1, 504, 376, 0, "reset mid move"};
        for (int i = 0; i < 6; i++) begin
            repeat (tbl[i].n) cyc(tbl[i].r, tbl[i].t, tbl[i].s);
            expect_v({tbl[i].nm, " x"}, int'(bus.o_x_ball), tbl[i].ex);
            expect_v({tbl[i].nm, " y"}, int'(bus.o_y_ball), tbl[i].ey);
            expect_v({tbl[i].nm, " active"}, int'(bus.o_ball_active), tbl[i].ea);
            expect_v({tbl[i].nm, " goals"}, int'(bus.o_goal_left | bus.o_goal_right), 0);
        end

        // right miss, serve ignored while scored, then hold countdown
        cyc(1, 0, 1);
        k = 0;
        while (mgr == 0 && k < 400) begin cyc(1, 1, 0); k++; end
        expect_v("goal_right pulse", int'(bus.o_goal_right), 1);
        expect_v("goal_right x", int'(bus.o_x_ball), W - B);
        cyc(1, 0, 1);
        expect_v("goal_right width", int'(bus.o_goal_right), 0);
        expect_v("serve in scored", int'(bus.o_ball_active), 0);
        repeat (HOLD - 1) cyc(1, 1, 0);
        expect_v("hold tick 59 x", int'(bus.o_x_ball), W - B);
        cyc(1, 1, 0);
        expect_v("hold tick 60 x", int'(bus.o_x_ball), CX);
        expect_v("hold tick 60 y", int'(bus.o_y_ball), CY);

        // rally: right paddle return, then left paddle hit
        follow_r = 1;
        cyc(1, 0, 1);
        k = 0;
        while (vx > 0 && k < 400) begin cyc(1, 1, 0); k++; end
        expect_v("right paddle x", int'(bus.o_x_ball), XPR - B);
        follow_l = 1;
        k = 0;
        while (!(vx < 0 && mx - mstep <= XPL) && k < 600) begin cyc(1, 1, 0); k++; end
        cyc(1, 1, 0);
        expect_v("left paddle x", int'(bus.o_x_ball), XPL);
        cyc(1, 1, 0);
        expect_v("after left hit x", int'(bus.o_x_ball), XPL + mstep);

        // left miss, then serve must head left and down
        follow_l = 0;
        k = 0;
        while (mgl == 0 && k < 800) begin cyc(1, 1, 0); k++; end
        expect_v("goal_left pulse", int'(bus.o_goal_left), 1);
        expect_v("goal_left x", int'(bus.o_x_ball), 0);
        cyc(1, 0, 0);
        expect_v("goal_left width", int'(bus.o_goal_left), 0);
        repeat (HOLD) cyc(1, 1, 0);
        expect_v("recentre after left goal", int'(bus.o_x_ball), CX);
        cyc(1, 0, 1);
        cyc(1, 1, 0);
        expect_v("serve toward left x", int'(bus.o_x_ball), CX - SP);
        expect_v("third serve down y", int'(bus.o_y_ball), CY + SP);

        // random play
        follow_r = 0;
        for (int i = 0; i < 15000; i++) begin
            follow_l = $urandom_range(0, 99) < 60;
            follow_r = $urandom_range(0, 99) < 60;
            pad_l = $urandom_range(0, 760);
            pad_r = $urandom_range(0, 760);
            cyc($urandom_range(0, 999) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
        end

        $display("paddle hits modelled: %0d", mhits);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
